// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM encoding and the small sigma functions.
// The compressor imports the same package, so the sigmas live here and not
// inside the scheduler.
package sha256_pkg;

    localparam int WORD_W  = 32;
    localparam int BLOCK_W = 512;
    localparam int ROUNDS  = 64;
    localparam int WIN_N   = BLOCK_W / WORD_W;   // 16 words in the window
    localparam int CTR_W   = $clog2(ROUNDS);     // 6-bit word counter

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01
    } state_e;

    typedef logic [WORD_W-1:0] word_t;
    typedef word_t [WIN_N-1:0] window_t;  // index 0 = oldest word

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    // Message-schedule sigma0: ROTR7 ^ ROTR18 ^ SHR3
    function automatic word_t sigma0_small(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    // Message-schedule sigma1: ROTR17 ^ ROTR19 ^ SHR10
    function automatic word_t sigma1_small(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Split a padded block into window words, W0 from the top bits
    function automatic window_t block_to_window(input logic [BLOCK_W-1:0] blk);
        window_t win;
        for (int i = 0; i < WIN_N; i++)
            win[i] = blk[BLOCK_W-1-WORD_W*i -: WORD_W];
        return win;
    endfunction

endpackage

// File: rtl/sha256_message_scheduler_w_expand_unit.sv
// Combinational next-word generator. Only the four taps the recurrence
// needs are ported in, so the rest of the window stays local to the top.
module w_expand_unit
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] wm2,    // W[t-2]
    input  logic [WORD_W-1:0] wm7,    // W[t-7]
    input  logic [WORD_W-1:0] wm15,   // W[t-15]
    input  logic [WORD_W-1:0] wm16,   // W[t-16]
    input  logic [WORD_W-1:0] unused_pad_n, // tied off by parent, see top
    output logic [WORD_W-1:0] wnext
);

    // Modulo-2^32 sum; carries out of bit 31 simply fall off
    always_comb begin
        wnext = sigma1_small(wm2) + wm7 + sigma0_small(wm15) + wm16;
    end

    logic unused_ok;
    assign unused_ok = ^unused_pad_n;

endmodule

// File: rtl/sha256_message_scheduler.sv
// SHA-256 message schedule expander. Loads one padded block on init and
// streams W0..W63, one word per clock, flagging the last word of a final
// block. The window always holds W[w_ctr .. w_ctr+15]; each RUN edge shifts
// it by one and appends the freshly expanded word.
module sha256_message_scheduler
    import sha256_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [BLOCK_W-1:0] block,
    input  logic               init,
    input  logic               final_blk,
    output logic [WORD_W-1:0]  w,
    output logic               mi,
    output logic               ml
);

    localparam logic [1:0]       ST_IDLE = IDLE;
    localparam logic [1:0]       ST_RUN  = RUN;
    localparam logic [CTR_W-1:0] LAST    = CTR_W'(ROUNDS - 1);

    logic [1:0]       state;
    logic [CTR_W-1:0] w_ctr;
    logic             fin_q;
    window_t          win;
    window_t          blk_win;
    word_t            wnext;

    assign blk_win = block_to_window(block);

    // Next window word: W[w_ctr+16] from the current window
    w_expand_unit u_expand (
        .wm2          (win[14]),
        .wm7          (win[9]),
        .wm15         (win[1]),
        .wm16         (win[0]),
        .unused_pad_n ('0),
        .wnext        (wnext)
    );

    // Valid/last decode straight off the registered state
    always_comb begin
        mi = (state == ST_RUN);
        ml = (state == ST_RUN) && (w_ctr == LAST) && fin_q;
    end

    // FSM, word counter, output word and schedule window
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            w_ctr <= '0;
            w     <= '0;
            fin_q <= 1'b0;
            win   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (init) begin
                        win   <= blk_win;
                        fin_q <= final_blk;
                        w     <= blk_win[0];
                        w_ctr <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_ctr == LAST) begin
                        // Done; init on this edge is deliberately ignored
                        state <= ST_IDLE;
                        w_ctr <= '0;
                        w     <= '0;
                        fin_q <= 1'b0;
                    end else begin
                        w_ctr <= w_ctr + 1'b1;
                        w     <= win[1];
                        win   <= {wnext, win[WIN_N-1:1]};
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    w_ctr <= '0;
                    w     <= '0;
                    fin_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_message_scheduler.sv
// Directed bench for the SHA-256 message scheduler using the "abc" block.
module tb_sha256_message_scheduler;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [511:0] block = '0;
    logic         init = 1'b0;
    logic         final_blk = 1'b0;
    logic [31:0]  w;
    logic         mi;
    logic         ml;

    int errors = 0;
    int checks = 0;

    logic [511:0] abc_blk;
    logic [31:0]  exp_w [0:20];
    logic [31:0]  cap_w  [0:63];
    logic         cap_mi [0:63];
    logic         cap_ml [0:63];

    localparam logic [31:0] W63_ABC = 32'h12b1edeb;

    sha256_message_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .block     (block),
        .init      (init),
        .final_blk (final_blk),
        .w         (w),
        .mi        (mi),
        .ml        (ml)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Record 64 cycles starting with the current (W0) cycle
    task automatic capture64();
        for (int i = 0; i < 64; i++) begin
            cap_w[i]  = w;
            cap_mi[i] = mi;
            cap_ml[i] = ml;
            tick();
        end
    endtask

    task automatic start(input logic fin, input logic hold);
        block     = abc_blk;
        final_blk = fin;
        init      = 1'b1;
        tick();
        if (!hold) init = 1'b0;
        final_blk = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        checks++;
        if (mi !== 1'b0 || w !== 32'h0 || ml !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: mi=%b ml=%b w=%h, need mi=0 ml=0 w=0", tag, mi, ml, w);
        end
    endtask

    task automatic check_counts(input string tag, input int want_ml_at);
        int nmi;
        int nml;
        nmi = 0;
        nml = 0;
        for (int i = 0; i < 64; i++) begin
            if (cap_mi[i] === 1'b1) nmi++;
            if (cap_ml[i] === 1'b1) nml++;
        end
        checks++;
        if (nmi != 64) begin
            errors++;
            $display("FAIL %s mi_count: got %0d need 64", tag, nmi);
        end
        checks++;
        if (want_ml_at < 0 && nml != 0) begin
            errors++;
            $display("FAIL %s ml_count: got %0d need 0", tag, nml);
        end else if (want_ml_at >= 0 && (nml != 1 || cap_ml[want_ml_at] !== 1'b1)) begin
            errors++;
            $display("FAIL %s ml_pos: count %0d, ml[63]=%b, need single pulse at 63", tag, nml, cap_ml[63]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (w !== 32'h0) begin errors++; $display("FAIL reset_w: got %h need 0", w); end
        checks++;
        if (mi !== 1'b0) begin errors++; $display("FAIL reset_mi: got %b need 0", mi); end
        checks++;
        if (ml !== 1'b0) begin errors++; $display("FAIL reset_ml: got %b need 0", ml); end
        checks++;
        if (dut.state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b need 00", dut.state); end
        checks++;
        if (dut.w_ctr !== 6'd0) begin errors++; $display("FAIL reset_ctr: got %0d need 0", dut.w_ctr); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_abc();
        start(1'b0, 1'b0);
        capture64();
        for (int i = 0; i <= 20; i++) begin
            checks++;
            if (cap_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL abc_W%0d: got %h need %h", i, cap_w[i], exp_w[i]);
            end
        end
        checks++;
        if (cap_w[63] !== W63_ABC) begin
            errors++;
            $display("FAIL abc_W63: got %h need %h", cap_w[63], W63_ABC);
        end
        check_counts("abc", -1);
        check_idle("abc");
    endtask

    task automatic test_final();
        start(1'b1, 1'b0);
        capture64();
        check_counts("final", 63);
        checks++;
        if (cap_w[63] !== W63_ABC) begin
            errors++;
            $display("FAIL final_W63: got %h need %h", cap_w[63], W63_ABC);
        end
        check_idle("final");
    endtask

    task automatic test_init_held();
        start(1'b0, 1'b1);
        capture64();
        check_counts("held", -1);
        check_idle("held");
        tick();
        checks++;
        if (mi !== 1'b1 || w !== 32'h61626380 || dut.w_ctr !== 6'd0) begin
            errors++;
            $display("FAIL held_restart: mi=%b w=%h ctr=%0d, need mi=1 w=61626380 ctr=0", mi, w, dut.w_ctr);
        end
        init = 1'b0;
        for (int i = 0; i < 64; i++) tick();
        check_idle("held_end");
    endtask

    task automatic test_abort();
        start(1'b1, 1'b0);
        for (int i = 0; i < 30; i++) tick();
        checks++;
        if (dut.w_ctr !== 6'd30 || mi !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: ctr=%0d mi=%b, need ctr=30 mi=1", dut.w_ctr, mi);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("abort");
        checks++;
        if (dut.state !== 2'b00 || dut.w_ctr !== 6'd0) begin
            errors++;
            $display("FAIL abort_state: state=%b ctr=%0d, need 00 and 0", dut.state, dut.w_ctr);
        end
        tick();
        check_idle("abort_hold");
        start(1'b0, 1'b0);
        capture64();
        checks++;
        if (cap_w[0] !== exp_w[0] || cap_w[16] !== exp_w[16] || cap_w[63] !== W63_ABC) begin
            errors++;
            $display("FAIL abort_rerun: W0=%h W16=%h W63=%h", cap_w[0], cap_w[16], cap_w[63]);
        end
        check_counts("abort_rerun", -1);
    endtask

    task automatic test_ignore_during_run();
        start(1'b0, 1'b0);
        for (int i = 0; i < 64; i++) begin
            if (i == 5) begin
                block     = {16{32'hdeadbeef}};
                init      = 1'b1;
                final_blk = 1'b1;
            end
            if (i == 7) begin
                init      = 1'b0;
                final_blk = 1'b0;
            end
            cap_w[i]  = w;
            cap_mi[i] = mi;
            cap_ml[i] = ml;
            tick();
        end
        for (int i = 0; i <= 20; i++) begin
            checks++;
            if (cap_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL ignore_W%0d: got %h need %h", i, cap_w[i], exp_w[i]);
            end
        end
        checks++;
        if (cap_w[63] !== W63_ABC) begin
            errors++;
            $display("FAIL ignore_W63: got %h need %h", cap_w[63], W63_ABC);
        end
        check_counts("ignore", -1);
        check_idle("ignore");
    endtask

    initial begin
        abc_blk = {32'h61626380, 448'h0, 32'h00000018};
        exp_w[0] = 32'h61626380;
        for (int i = 1; i <= 14; i++) exp_w[i] = 32'h0;
        exp_w[15] = 32'h00000018;
        exp_w[16] = 32'h61626380;
        exp_w[17] = 32'h000f0000;
        exp_w[18] = 32'h7da86405;
        exp_w[19] = 32'h600003c6;
        exp_w[20] = 32'h3e9d7b78;

        test_reset();
        test_abc();
        tick();
        test_final();
        test_init_held();
        test_abort();
        tick();
        test_ignore_during_run();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
